// File: rtl/j1_dbus_wb_bridge_if.sv
// Wishbone classic master bus bundle for the J1 dbus bridge.
// master: bridge side (drives cyc/stb/we/adr/dat/sel); slave: bus side.
interface j1_dbus_wb_bridge_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/j1_dbus_wb_bridge.sv
// J1 dbus to Wishbone classic bridge: one cycle in flight, stall, sticky err.
// Ports: clk, reset_n (async low), dbus_* core side, stall, err/err_clr,
// wb (master modport). Optional macro J1_WB_POSTED_WRITE_EN enables
// posted writes and back-to-back acceptance from the POST state.
module j1_dbus_wb_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [15:0] ERR_RDATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dbus_adr,
    input  logic        dbus_re,
    input  logic        dbus_we,
    input  logic [15:0] dbus_wdat,
    output logic [15:0] dbus_rdat,
    output logic        stall,
    output logic        err,
    input  logic        err_clr,
    j1_dbus_wb_bridge_if.master wb
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
`ifdef J1_WB_POSTED_WRITE_EN
    localparam logic [1:0] S_POST  = 2'd3;
`endif
    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] tcnt;

    logic        req;
    logic        busy;
    logic        t_hit;
    logic        fail;
    logic        done;
    logic        accept;
    logic [1:0]  wr_state;

    assign wb.wb_cyc_o = cyc;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = we;
    assign wb.wb_adr_o = adr;
    assign wb.wb_dat_o = dat;
    assign wb.wb_sel_o = 2'b11;

    always_comb begin
        req   = dbus_re | dbus_we;
        busy  = (state != S_IDLE);
        // Timeout fires on the last allowed stb cycle with no response.
        t_hit = stb & ~wb.wb_ack_i & ~wb.wb_err_i & (tcnt == T_LAST);
        fail  = busy & (wb.wb_err_i | t_hit);
        done  = busy & (wb.wb_ack_i | wb.wb_err_i | t_hit);
`ifdef J1_WB_POSTED_WRITE_EN
        wr_state = S_POST;
        // A pending request rides the POST termination edge.
        accept = req & ((state == S_IDLE) |
                        ((state == S_POST) & done));
        stall  = (state == S_READ) | (state == S_WRITE) |
                 ((state == S_POST) & req);
`else
        wr_state = S_WRITE;
        accept   = req & (state == S_IDLE);
        stall    = (state == S_READ) | (state == S_WRITE);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            adr       <= 16'h0000;
            dat       <= 16'h0000;
            tcnt      <= 16'h0000;
            dbus_rdat <= 16'h0000;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                state <= dbus_we ? wr_state : S_READ;
                cyc   <= 1'b1;
                stb   <= 1'b1;
                we    <= dbus_we;
                adr   <= dbus_adr;
                dat   <= dbus_wdat;
                tcnt  <= 16'h0000;
            end else if (done) begin
                state <= S_IDLE;
                cyc   <= 1'b0;
                stb   <= 1'b0;
            end else if (stb) begin
                tcnt <= tcnt + 16'h0001;
            end

            if (done && (state == S_READ))
                dbus_rdat <= fail ? ERR_RDATA : wb.wb_dat_i;

            // A new error beats a simultaneous clear.
            if (fail)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_j1_dbus_wb_bridge.sv
// Directed bench for j1_dbus_wb_bridge with a scripted Wishbone slave.
// Covers reads, writes, timeout, err, err_clr, mid-cycle reset.
module tb_j1_dbus_wb_bridge;
`ifdef J1_WB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_NONE = 2;
    localparam int R_BOTH = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] dbus_adr = '0;
    logic        dbus_re = 1'b0;
    logic        dbus_we = 1'b0;
    logic [15:0] dbus_wdat = '0;
    logic [15:0] dbus_rdat;
    logic        stall;
    logic        err;
    logic        err_clr = 1'b0;

    int total = 0;
    int passed = 0;

    j1_dbus_wb_bridge_if wb ();

    j1_dbus_wb_bridge #(
        .TIMEOUT   (8),
        .ERR_RDATA (16'hFFFF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dbus_adr  (dbus_adr),
        .dbus_re   (dbus_re),
        .dbus_we   (dbus_we),
        .dbus_wdat (dbus_wdat),
        .dbus_rdat (dbus_rdat),
        .stall     (stall),
        .err       (err),
        .err_clr   (err_clr),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] adr;
        logic [15:0] wdat;
        int          waits;
        int          resp;
        logic [15:0] sdat;
        logic        clr;
        logic [15:0] exp_rdat;
        logic        exp_err;
        int          exp_cyc;
        int          exp_stall;
    } vec_t;

    vec_t tab [12];

    function automatic int ws(input int n);
        return POSTED ? 0 : n;
    endfunction

    function automatic vec_t mk(
        input logic re, input logic we,
        input logic [15:0] adr, input logic [15:0] wdat,
        input int waits, input int resp,
        input logic [15:0] sdat, input logic clr,
        input logic [15:0] er, input logic ee,
        input int ec, input int es
    );
        vec_t v;
        v.re = re; v.we = we; v.adr = adr; v.wdat = wdat;
        v.waits = waits; v.resp = resp; v.sdat = sdat;
        v.clr = clr; v.exp_rdat = er; v.exp_err = ee;
        v.exp_cyc = ec; v.exp_stall = es;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s got=%h want=%h t=%0t",
                     name, act, exp, $time);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 16'(err), 16'h0);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int cycs;
        int stalls;
        cycs = 0;
        stalls = 0;
        if (v.clr)
            pulse_clr();
        @(negedge clk);
        dbus_re   = v.re;
        dbus_we   = v.we;
        dbus_adr  = v.adr;
        dbus_wdat = v.wdat;
        @(negedge clk);
        dbus_re = 1'b0;
        dbus_we = 1'b0;
        chk($sformatf("v%0d adr", k), wb.wb_adr_o, v.adr);
        chk($sformatf("v%0d we", k), 16'(wb.wb_we_o), 16'(v.we));
        if (v.we)
            chk($sformatf("v%0d dat", k), wb.wb_dat_o, v.wdat);
        for (int i = 0; i < 64 && wb.wb_cyc_o; i++) begin
            cycs++;
            if (stall)
                stalls++;
            if (i == v.waits) begin
                wb.wb_ack_i = (v.resp == R_ACK) || (v.resp == R_BOTH);
                wb.wb_err_i = (v.resp == R_ERR) || (v.resp == R_BOTH);
                wb.wb_dat_i = v.sdat;
            end
            @(negedge clk);
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
        end
        chk($sformatf("v%0d cyc_len", k), 16'(cycs), 16'(v.exp_cyc));
        chk($sformatf("v%0d stall_len", k), 16'(stalls),
            16'(v.exp_stall));
        chk($sformatf("v%0d stall_end", k), 16'(stall), 16'h0);
        chk($sformatf("v%0d rdat", k), dbus_rdat, v.exp_rdat);
        chk($sformatf("v%0d err", k), 16'(err), 16'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        wb.wb_dat_i = '0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;

        tab[0]  = mk(1, 0, 16'h0123, 16'h0, 0, R_ACK, 16'hBEEF, 0,
                     16'hBEEF, 0, 1, 1);
        tab[1]  = mk(1, 0, 16'h0040, 16'h0, 2, R_ACK, 16'h5A5A, 0,
                     16'h5A5A, 0, 3, 3);
        tab[2]  = mk(0, 1, 16'h0010, 16'hA5A5, 3, R_ACK, 16'h0, 0,
                     16'h5A5A, 0, 4, ws(4));
        tab[3]  = mk(1, 0, 16'h0055, 16'h0, 0, R_NONE, 16'h0, 0,
                     16'hFFFF, 1, 8, 8);
        tab[4]  = mk(1, 0, 16'h0060, 16'h0, 0, R_ACK, 16'h1111, 1,
                     16'h1111, 0, 1, 1);
        tab[5]  = mk(0, 1, 16'h0011, 16'h7777, 1, R_ERR, 16'h0, 0,
                     16'h1111, 1, 2, ws(2));
        tab[6]  = mk(1, 0, 16'h0066, 16'h0, 0, R_ACK, 16'h2222, 1,
                     16'h2222, 0, 1, 1);
        tab[7]  = mk(1, 0, 16'h0077, 16'h0, 1, R_ERR, 16'h9999, 0,
                     16'hFFFF, 1, 2, 2);
        tab[8]  = mk(1, 0, 16'h0078, 16'h0, 0, R_ACK, 16'h3333, 1,
                     16'h3333, 0, 1, 1);
        tab[9]  = mk(1, 0, 16'h0079, 16'h0, 0, R_BOTH, 16'h4444, 0,
                     16'hFFFF, 1, 1, 1);
        tab[10] = mk(1, 1, 16'h00AA, 16'h0F0F, 0, R_ACK, 16'h5555, 1,
                     16'hFFFF, 0, 1, ws(1));
        tab[11] = mk(0, 1, 16'h0012, 16'h1357, 0, R_NONE, 16'h0, 0,
                     16'hFFFF, 1, 8, ws(8));

        repeat (2) @(negedge clk);
        chk("rst cyc", 16'(wb.wb_cyc_o), 16'h0);
        chk("rst stb", 16'(wb.wb_stb_o), 16'h0);
        chk("rst we", 16'(wb.wb_we_o), 16'h0);
        chk("rst adr", wb.wb_adr_o, 16'h0);
        chk("rst dat", wb.wb_dat_o, 16'h0);
        chk("rst rdat", dbus_rdat, 16'h0);
        chk("rst err", 16'(err), 16'h0);
        chk("rst stall", 16'(stall), 16'h0);
        chk("sel", 16'(wb.wb_sel_o), 16'h3);
        reset_n = 1'b1;

        for (int k = 0; k < 12; k++)
            run_vec(k, tab[k]);

        // err event and err_clr in the same cycle: err must stay set.
        pulse_clr();
        @(negedge clk);
        dbus_re  = 1'b1;
        dbus_adr = 16'h0100;
        @(negedge clk);
        dbus_re     = 1'b0;
        wb.wb_err_i = 1'b1;
        err_clr     = 1'b1;
        @(negedge clk);
        wb.wb_err_i = 1'b0;
        err_clr     = 1'b0;
        chk("errclr_race err", 16'(err), 16'h1);
        chk("errclr_race rdat", dbus_rdat, 16'hFFFF);
        chk("errclr_race cyc", 16'(wb.wb_cyc_o), 16'h0);
        pulse_clr();

`ifdef J1_WB_POSTED_WRITE_EN
        // Posted write then a read waiting behind it, back to back.
        @(negedge clk);
        dbus_we   = 1'b1;
        dbus_adr  = 16'h0010;
        dbus_wdat = 16'hA5A5;
        @(negedge clk);
        dbus_we  = 1'b0;
        dbus_re  = 1'b1;
        dbus_adr = 16'h0020;
        chk("b2b stall_w0", 16'(stall), 16'h1);
        chk("b2b dat", wb.wb_dat_o, 16'hA5A5);
        @(negedge clk);
        chk("b2b stall_w1", 16'(stall), 16'h1);
        chk("b2b we_w", 16'(wb.wb_we_o), 16'h1);
        wb.wb_ack_i = 1'b1;
        @(negedge clk);
        wb.wb_ack_i = 1'b0;
        chk("b2b cyc_held", 16'(wb.wb_cyc_o), 16'h1);
        chk("b2b we_r", 16'(wb.wb_we_o), 16'h0);
        chk("b2b adr_r", wb.wb_adr_o, 16'h0020);
        chk("b2b stall_r", 16'(stall), 16'h1);
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 16'h1234;
        @(negedge clk);
        wb.wb_ack_i = 1'b0;
        chk("b2b stall_end", 16'(stall), 16'h0);
        chk("b2b cyc_end", 16'(wb.wb_cyc_o), 16'h0);
        chk("b2b rdat", dbus_rdat, 16'h1234);
        dbus_re = 1'b0;
`endif

        // Asynchronous reset in the middle of a read.
        @(negedge clk);
        dbus_re  = 1'b1;
        dbus_adr = 16'h0200;
        @(negedge clk);
        dbus_re = 1'b0;
        chk("mid cyc_on", 16'(wb.wb_cyc_o), 16'h1);
        chk("mid stall_on", 16'(stall), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid cyc", 16'(wb.wb_cyc_o), 16'h0);
        chk("mid stb", 16'(wb.wb_stb_o), 16'h0);
        chk("mid stall", 16'(stall), 16'h0);
        chk("mid rdat", dbus_rdat, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post cyc", 16'(wb.wb_cyc_o), 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/j1_dbus_wb_bridge.md
Name: j1_dbus_wb_bridge

Overview:
Downstream stage of the J1 core's data bus. Converts the core's single-cycle dbus read/write strobes into Wishbone classic master cycles. Asserts a stall that freezes the core while a cycle is in flight. Holds at most one posted write, and flags bus errors and timeouts in a sticky status bit.

Parameters:
TIMEOUT, 255, max cycles wb_stb_o stays high without ack/err before the bridge self-terminates (1..65535)
ERR_RDATA, 16'hFFFF, value returned to the core for a read ending in err or timeout

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
dbus_adr  in  16  word address from core
dbus_re  in  1  read strobe from core
dbus_we  in  1  write strobe from core
dbus_wdat  in  16  write data from core
dbus_rdat  out  16  read data to core
stall  out  1  freeze request to core (clock-enable gate, combinational)
err  out  1  sticky error flag
err_clr  in  1  clears err
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  16  Wishbone word address
wb_dat_o  out  16  Wishbone write data
wb_sel_o  out  2  byte selects, constant 2'b11
wb_dat_i  in  16  Wishbone read data
wb_ack_i  in  1  Wishbone ack
wb_err_i  in  1  Wishbone error

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - state=IDLE
  - wb_cyc_o/wb_stb_o/wb_we_o=0
  - wb_adr_o/wb_dat_o=0
  - dbus_rdat=0, err=0, timeout counter=0
- Reset mid-cycle: the Wishbone cycle is abandoned immediately (cyc/stb drop asynchronously). Nothing is replayed.
- States: IDLE, READ, WRITE, POST.
- Acceptance: a request is accepted on a rising edge where (dbus_re|dbus_we)=1 and stall=0.
  - If both strobes are high, the write is performed and the read is ignored.
  - adr/wdat are latched into wb_adr_o/wb_dat_o. wb_cyc_o=wb_stb_o=1 from the next cycle (registered outputs).
- stall (combinational):
  - 1 while state is READ or WRITE.
  - 1 in POST while (dbus_re|dbus_we)=1.
  - Otherwise 0.
- IDLE:
  - re → READ, wb_we_o=0.
  - we → POST (posted) or WRITE (unposted; see Optional Feature), wb_we_o=1.
- READ:
  - On ack: dbus_rdat<=wb_dat_i, → IDLE.
  - On err or timeout: dbus_rdat<=ERR_RDATA, err<=1, → IDLE.
  - stall stays 1 through the ack cycle. Data is valid and stall=0 on the following cycle.
  - Zero-wait slave: stall high for exactly 1 core cycle.
- WRITE/POST:
  - On ack: → IDLE.
  - On err/timeout: err<=1, → IDLE.
  - If a new request is pending in the POST ack cycle, it is accepted at that same edge: state → READ/POST/WRITE, cyc stays 1, stb stays 1, and adr/dat/we are updated (back-to-back, no idle cycle).
- Cycle deassertion: cyc/stb deassert on the edge after ack/err/timeout unless a back-to-back request is accepted.
- dbus_rdat holds its last value between reads. Writes never modify it.
- Timeout counter:
  - Reset to 0 on each accepted request; increments every cycle with stb=1 and no ack/err.
  - Reaching TIMEOUT terminates the cycle as an error.
  - Counter width is 16 bits; it does not wrap because termination occurs first.
- Same-cycle ack and err: err wins.
- err clears on err_clr=1 at the next edge. An error event in the same cycle as err_clr wins (err stays 1).

Optional Feature:
J1_WB_POSTED_WRITE_EN
- Defined: writes go to POST; stall=0 for the write itself, so the core continues while the write completes.
- Undefined: writes go to WRITE and stall like reads until ack/err/timeout. The POST state and back-to-back acceptance are not synthesised. Behaviour otherwise identical.

Test Plan:
- Reset release; re=1, adr=16'h0123; slave acks in the first stb cycle with 16'hBEEF → wb_adr_o=16'h0123, wb_we_o=0, stall high 1 cycle, then dbus_rdat=16'hBEEF with stall=0.
- Posted write: we=1, adr=16'h0010, wdat=16'hA5A5; slave acks after 3 wait cycles → stall stays 0, wb_dat_o=16'hA5A5, cyc high 4 cycles then 0.
- Posted write in flight plus re to adr 16'h0020 → stall=1 until the write ack; the read starts the next edge with cyc held high. The ack data 16'h1234 is returned on dbus_rdat.
- Slave never acks, TIMEOUT=8 → cyc drops after 8 stb cycles, dbus_rdat=16'hFFFF, err=1. err_clr pulse → err=0.
- wb_err_i on a read → err=1, dbus_rdat=ERR_RDATA. Same-cycle err and err_clr → err stays 1.
- reset_n asserted mid-read → cyc/stb/stall 0 immediately, dbus_rdat=0; with the macro undefined, a write stalls until ack.
